// File: rtl/traffic_phase_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_phase_controller                                                   |
// | Tick-timed phase sequencer for a main/side road junction with ped crossing |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module traffic_phase_controller #(
    parameter int MAIN_GREEN_MIN  = 8,
    parameter int SIDE_GREEN_TIME = 5,
    parameter int YELLOW_TIME     = 3,
    parameter int ALL_RED_TIME    = 1
) (
    input  logic       clk,
    input  logic       global_reset_n,
    input  logic       enable_1Hz,
    input  logic       side_request,
    input  logic       ped_request,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk,
    output logic [4:0] countdown,
    output logic [2:0] phase
);

    localparam logic [2:0] c_MAIN_GREEN  = 3'd0;
    localparam logic [2:0] c_MAIN_YELLOW = 3'd1;
    localparam logic [2:0] c_ALL_RED_A   = 3'd2;
    localparam logic [2:0] c_SIDE_GREEN  = 3'd3;
    localparam logic [2:0] c_SIDE_YELLOW = 3'd4;
    localparam logic [2:0] c_ALL_RED_B   = 3'd5;

    localparam logic [2:0] c_RED = 3'b100;
    localparam logic [2:0] c_YEL = 3'b010;
    localparam logic [2:0] c_GRN = 3'b001;

    localparam logic [4:0] c_MGM = 5'(MAIN_GREEN_MIN);
    localparam logic [4:0] c_SGT = 5'(SIDE_GREEN_TIME);
    localparam logic [4:0] c_YT  = 5'(YELLOW_TIME);
    localparam logic [4:0] c_ART = 5'(ALL_RED_TIME);

    logic [2:0] r_state;
    logic [4:0] r_timer;
    logic       r_pend_side;
    logic       r_pend_ped;
    logic       r_walk_en;
    logic [2:0] r_main_light;
    logic [2:0] r_side_light;
    logic       r_ped_walk;
    logic [4:0] r_countdown;

    logic [2:0] w_state_nxt;
    logic [4:0] w_timer_nxt;
    logic [4:0] w_dur;
    logic [4:0] w_dur_nxt;
    logic       w_timed_done;
    logic       w_any_req;
    logic       w_enter_sg;
    logic       w_walk_nxt;
    logic       w_pend_side_nxt;
    logic       w_pend_ped_nxt;
    logic [2:0] w_main_nxt;
    logic [2:0] w_side_nxt;
    logic [4:0] w_cd_nxt;

    function automatic logic [4:0] phase_dur(input logic [2:0] st);
        case (st)
            c_MAIN_YELLOW, c_SIDE_YELLOW: phase_dur = c_YT;
            c_SIDE_GREEN:                 phase_dur = c_SGT;
            default:                      phase_dur = c_ART;
        endcase
    endfunction

    always_comb begin
        w_dur        = phase_dur(r_state);
        w_timed_done = enable_1Hz && (r_timer == w_dur - 5'd1);
        w_any_req    = r_pend_side | r_pend_ped | side_request | ped_request;
        w_state_nxt  = r_state;
        case (r_state)
            c_MAIN_GREEN:  if (enable_1Hz && (r_timer >= c_MGM - 5'd1) && w_any_req)
                               w_state_nxt = c_MAIN_YELLOW;
            c_MAIN_YELLOW: if (w_timed_done) w_state_nxt = c_ALL_RED_A;
            c_ALL_RED_A:   if (w_timed_done) w_state_nxt = c_SIDE_GREEN;
            c_SIDE_GREEN:  if (w_timed_done) w_state_nxt = c_SIDE_YELLOW;
            c_SIDE_YELLOW: if (w_timed_done) w_state_nxt = c_ALL_RED_B;
            c_ALL_RED_B:   if (w_timed_done) w_state_nxt = c_MAIN_GREEN;
            default:       w_state_nxt = c_ALL_RED_B;
        endcase

        // Any state change (including recovery from an illegal code) restarts the timer.
        if (w_state_nxt != r_state)
            w_timer_nxt = 5'd0;
        else if (enable_1Hz && (r_timer != 5'd31))
            w_timer_nxt = r_timer + 5'd1;
        else
            w_timer_nxt = r_timer;

        w_enter_sg      = (w_state_nxt == c_SIDE_GREEN) && (r_state != c_SIDE_GREEN);
        w_pend_side_nxt = w_enter_sg ? 1'b0 : (r_pend_side | side_request);
        w_pend_ped_nxt  = w_enter_sg ? 1'b0 : (r_pend_ped | ped_request);
        if (w_enter_sg)
            w_walk_nxt = r_pend_ped | ped_request;
        else if (w_state_nxt != c_SIDE_GREEN)
            w_walk_nxt = 1'b0;
        else
            w_walk_nxt = r_walk_en;

        // Outputs are decoded from the next state so they change on the same edge.
        w_main_nxt = c_RED;
        w_side_nxt = c_RED;
        case (w_state_nxt)
            c_MAIN_GREEN:  w_main_nxt = c_GRN;
            c_MAIN_YELLOW: w_main_nxt = c_YEL;
            c_SIDE_GREEN:  w_side_nxt = c_GRN;
            c_SIDE_YELLOW: w_side_nxt = c_YEL;
            default:       ;
        endcase
        w_dur_nxt = phase_dur(w_state_nxt);
        if (w_state_nxt == c_MAIN_GREEN)
            w_cd_nxt = (w_timer_nxt < c_MGM) ? (c_MGM - w_timer_nxt) : 5'd0;
        else
            w_cd_nxt = w_dur_nxt - w_timer_nxt;
    end

    always_ff @(posedge clk) begin
        if (!global_reset_n) begin
            r_state      <= c_ALL_RED_B;
            r_timer      <= 5'd0;
            r_pend_side  <= 1'b0;
            r_pend_ped   <= 1'b0;
            r_walk_en    <= 1'b0;
            r_main_light <= c_RED;
            r_side_light <= c_RED;
            r_ped_walk   <= 1'b0;
            r_countdown  <= c_ART;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_pend_side  <= w_pend_side_nxt;
            r_pend_ped   <= w_pend_ped_nxt;
            r_walk_en    <= w_walk_nxt;
            r_main_light <= w_main_nxt;
            r_side_light <= w_side_nxt;
            r_ped_walk   <= w_walk_nxt && (w_state_nxt == c_SIDE_GREEN);
            r_countdown  <= w_cd_nxt;
        end
    end

    assign main_light = r_main_light;
    assign side_light = r_side_light;
    assign ped_walk   = r_ped_walk;
    assign countdown  = r_countdown;
    assign phase      = r_state;

    a_no_conflict: assert property (@(posedge clk)
        !((main_light[0] | main_light[1]) && (side_light[0] | side_light[1])));

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_traffic_phase_controller                                                |
// | Directed self-checking bench for traffic_phase_controller                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_traffic_phase_controller;

    logic       clk;
    logic       global_reset_n;
    logic       enable_1Hz;
    logic       side_request;
    logic       ped_request;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       ped_walk;
    logic [4:0] countdown;
    logic [2:0] phase;

    int n_pass;
    int n_total;

    traffic_phase_controller dut (
        .clk           (clk),
        .global_reset_n(global_reset_n),
        .enable_1Hz    (enable_1Hz),
        .side_request  (side_request),
        .ped_request   (ped_request),
        .main_light    (main_light),
        .side_light    (side_light),
        .ped_walk      (ped_walk),
        .countdown     (countdown),
        .phase         (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Lamp pattern implied by each phase code.
    task automatic expect_phase(input string tag, input logic [2:0] ph,
                                input logic [4:0] cd, input logic walk);
        logic [2:0] m;
        logic [2:0] s;
        m = 3'b100;
        s = 3'b100;
        case (ph)
            3'd0: m = 3'b001;
            3'd1: m = 3'b010;
            3'd3: s = 3'b001;
            3'd4: s = 3'b010;
            default: ;
        endcase
        chk({tag, ".phase"}, {5'd0, phase}, {5'd0, ph});
        chk({tag, ".main"}, {5'd0, main_light}, {5'd0, m});
        chk({tag, ".side"}, {5'd0, side_light}, {5'd0, s});
        chk({tag, ".walk"}, {7'd0, ped_walk}, {7'd0, walk});
        chk({tag, ".cd"}, {3'd0, countdown}, {3'd0, cd});
    endtask

    task automatic tick();
        enable_1Hz = 1'b1;
        @(negedge clk);
        enable_1Hz = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        global_reset_n = 1'b0;
        @(negedge clk);
        global_reset_n = 1'b1;
    endtask

    task automatic pulse(input logic s, input logic p);
        side_request = s;
        ped_request  = p;
        @(negedge clk);
        side_request = 1'b0;
        ped_request  = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        global_reset_n = 1'b0;
        enable_1Hz = 1'b0;
        side_request = 1'b0;
        ped_request = 1'b0;
        repeat (2) @(negedge clk);
        global_reset_n = 1'b1;
        expect_phase("rst", 3'd5, 5'd1, 1'b0);

        // Idle: ALL_RED_B one tick, then MAIN_GREEN held with saturating timer
        tick();
        expect_phase("idle_mg0", 3'd0, 5'd8, 1'b0);
        ticks(3);
        expect_phase("idle_mg3", 3'd0, 5'd5, 1'b0);
        ticks(5);
        expect_phase("idle_mg8", 3'd0, 5'd0, 1'b0);
        ticks(92);
        expect_phase("idle_mg100", 3'd0, 5'd0, 1'b0);

        // Side request at tick 2 of MAIN_GREEN
        do_reset();
        tick();
        ticks(2);
        pulse(1'b1, 1'b0);
        ticks(5);
        expect_phase("sr_mg7", 3'd0, 5'd1, 1'b0);
        tick();
        expect_phase("sr_my", 3'd1, 5'd3, 1'b0);
        ticks(2);
        expect_phase("sr_my2", 3'd1, 5'd1, 1'b0);
        tick();
        expect_phase("sr_ara", 3'd2, 5'd1, 1'b0);
        tick();
        expect_phase("sr_sg", 3'd3, 5'd5, 1'b0);
        ticks(4);
        expect_phase("sr_sg4", 3'd3, 5'd1, 1'b0);
        tick();
        expect_phase("sr_sy", 3'd4, 5'd3, 1'b0);
        ticks(3);
        expect_phase("sr_arb", 3'd5, 5'd1, 1'b0);
        tick();
        expect_phase("sr_mg", 3'd0, 5'd8, 1'b0);
        ticks(10);
        expect_phase("sr_mg10", 3'd0, 5'd0, 1'b0);

        // Ped request after minimum green: immediate service, WALK through SIDE_GREEN
        pulse(1'b0, 1'b1);
        tick();
        expect_phase("pr_my", 3'd1, 5'd3, 1'b0);
        ticks(3);
        expect_phase("pr_ara", 3'd2, 5'd1, 1'b0);
        tick();
        expect_phase("pr_sg", 3'd3, 5'd5, 1'b1);
        for (int i = 1; i < 5; i++) begin
            tick();
            expect_phase("pr_sgN", 3'd3, 5'(5 - i), 1'b1);
        end
        tick();
        expect_phase("pr_sy", 3'd4, 5'd3, 1'b0);
        ticks(4);
        expect_phase("pr_mg", 3'd0, 5'd8, 1'b0);

        // Side request held high
        side_request = 1'b1;
        ticks(7);
        expect_phase("hold_mg7", 3'd0, 5'd1, 1'b0);
        tick();
        expect_phase("hold_my", 3'd1, 5'd3, 1'b0);
        ticks(4);
        expect_phase("hold_sg", 3'd3, 5'd5, 1'b0);
        ticks(5);
        expect_phase("hold_sy", 3'd4, 5'd3, 1'b0);
        ticks(4);
        expect_phase("hold_mg", 3'd0, 5'd8, 1'b0);
        ticks(7);
        expect_phase("hold_mg7b", 3'd0, 5'd1, 1'b0);
        tick();
        expect_phase("hold_my2", 3'd1, 5'd3, 1'b0);
        side_request = 1'b0;

        // Reset in the middle of SIDE_GREEN with requests latched
        ticks(4);
        expect_phase("mr_sg", 3'd3, 5'd5, 1'b0);
        tick();
        pulse(1'b1, 1'b1);
        do_reset();
        expect_phase("mr_rst", 3'd5, 5'd1, 1'b0);
        tick();
        expect_phase("mr_mg", 3'd0, 5'd8, 1'b0);
        ticks(12);
        expect_phase("mr_mg12", 3'd0, 5'd0, 1'b0);

        // Illegal state code recovers to ALL_RED_B
        force dut.r_state = 3'd7;
        #1;
        release dut.r_state;
        @(negedge clk);
        expect_phase("illegal", 3'd5, 5'd1, 1'b0);

        // Random requests and ticks: lamps must never conflict
        for (int i = 0; i < 10000; i++) begin
            enable_1Hz   = ($urandom_range(3) == 0);
            side_request = ($urandom_range(15) == 0);
            ped_request  = ($urandom_range(15) == 0);
            @(negedge clk);
            chk("safety", {7'd0, (main_light[0] | main_light[1]) & (side_light[0] | side_light[1])}, 8'd0);
            chk("phase_legal", {7'd0, phase > 3'd5}, 8'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
